mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer for a shared 4:1 data multiplexer. Four requesters present data with a request line; the block picks one fairly, drives the mux select, captures the selected word into an output register and hands it to a single downstream consumer over a valid/ready handshake, acknowledging the winning requester when the word is accepted. It sits between the requester-side mux inputs and the shared consumer.

## Interface
Parameters:
- WIDTH, 8, data width of each requester word and of out_data.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester request; bit i asserts that in_data word i is valid.
- in_data  input  4*WIDTH  packed requester data; word i = in_data[i*WIDTH +: WIDTH].
- ack  output  4  one-hot, one-cycle pulse to the requester whose word was accepted downstream.
- sel  output  2  current mux select / granted requester index.
- out_valid  output  1  out_data holds a granted word.
- out_ready  input  1  consumer accepts out_data when high with out_valid.
- out_data  output  WIDTH  registered selected word.
- busy  output  1  high in state GRANT.

## Operation
- Reset (asynchronous, immediate): state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0, ack=0, busy=0.
- State IDLE: if req==0, stay in IDLE; outputs unchanged except ack=0. Otherwise the winner is the first set req bit searching ptr, ptr+1, … modulo 4. On the edge: sel<=winner, out_data<=word[winner], out_valid<=1, busy<=1, state<=GRANT.
- State GRANT: out_data and sel held constant. On an edge with out_valid && out_ready: ack[sel]<=1 for exactly one cycle, out_valid<=0, busy<=0, ptr<=(sel+1) mod 4 (3 wraps to 0), state<=IDLE.
- ack is registered and one-hot; it is never asserted in the same cycle as out_valid for a new grant.
- A requester holds req and its data stable until its ack. It must deassert req in the cycle ack is seen, otherwise it is eligible again under the normal round-robin order.
- A requester dropping req while granted does not abort the transfer: the word is already latched, and ack still pulses.
- req changes during GRANT are ignored until the return to IDLE.
- ptr advances only on a completed transfer, never on reset-free idle cycles.

## Timing
- Arbitration latency: req sampled high at edge T in IDLE, so out_valid=1 after edge T.
- Handshake completes at the first edge where out_valid && out_ready. ack is high for the following cycle; IDLE is re-entered in that same cycle.
- Maximum throughput: one transfer per 2 cycles, with out_ready tied high (IDLE cycle plus GRANT cycle).
- out_ready low holds GRANT indefinitely, with out_data, sel and out_valid stable.
- Fairness: with all four requests continuously asserted, grants occur in rotating order, and each requester waits at most 3 other transfers.
- Reset asserted mid-GRANT: out_valid drops asynchronously, no ack is issued, and the word is lost. The requester keeps req high and is re-served after reset deasserts.

## Test plan
- Reset check: assert rst with random inputs, then deassert rst → out_valid=0, ack=0, sel=0, out_data=0, busy=0. Then set req=4'b0100, in_data word2=8'hA5 → one cycle later out_valid=1, sel=2, out_data=8'hA5.
- Single requester with backpressure: req=4'b0001, word0=8'h3C, out_ready low for 5 cycles then high → out_valid and out_data=8'h3C held for 5 cycles; ack=4'b0001 for exactly one cycle after acceptance.
- Full contention: req=4'b1111 held, each requester dropping req on its ack and re-raising it next cycle, out_ready=1 → grant order sel=0,1,2,3,0,1; one transfer every 2 cycles.
- Pointer wrap: complete one transfer for requester 3, then set req=4'b1001 → next grant sel=0. Then set req=4'b1010 → next grant sel=1, not 3.
- Request withdrawal: grant requester 1 (word1=8'h77), drop req[1] during GRANT, then raise out_ready → out_data=8'h77 accepted and ack=4'b0010 pulses.
- Reset mid-GRANT: with out_valid=1, out_ready=0, pulse rst → out_valid falls immediately, no ack. After release, with req still high, the request is re-granted from ptr=0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 data mux: picks a requester fairly, registers its word
// and hands it to one consumer over valid/ready, pulsing ack to the winner on acceptance.
module mux_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         ack,
   output logic [1:0]         sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [1:0]         ptr_r;
   logic [1:0]         ptr_s;
   logic [1:0]         sel_s;
   logic               out_valid_s;
   logic [WIDTH-1:0]   out_data_s;
   logic [3:0]         ack_s;
   logic               busy_s;
   logic               found_s;
   logic [1:0]         win_s;
   logic [WIDTH-1:0]   word_s;

   // Search ptr, ptr+1, ... modulo 4; the smallest offset from ptr wins, so scan offsets downward.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   // Winner selection and the candidate word routed through the mux.
   always_comb begin
      {found_s, win_s} = rr_pick(req, ptr_r);
      word_s           = in_data[int'(win_s)*WIDTH +: WIDTH];
   end

   // Next-state and next-output logic; ack defaults low so it can only ever be a single-cycle pulse.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      sel_s       = sel;
      out_valid_s = out_valid;
      out_data_s  = out_data;
      ack_s       = 4'b0000;
      busy_s      = busy;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s     = GRANT;
               sel_s       = win_s;
               out_data_s  = word_s;
               out_valid_s = 1'b1;
               busy_s      = 1'b1;
            end else begin
               state_s     = IDLE;
            end
         end
         GRANT: begin
            if (out_valid && out_ready) begin
               state_s     = IDLE;
               ack_s       = onehot4(sel);
               out_valid_s = 1'b0;
               busy_s      = 1'b0;
               ptr_s       = sel + 2'd1;
            end else begin
               state_s     = GRANT;
            end
         end
         default: begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
            busy_s      = 1'b0;
         end
      endcase
   end

   // State and output registers; reset discards any word in flight without acknowledging it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         ptr_r     <= 2'd0;
         sel       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= {WIDTH{1'b0}};
         ack       <= 4'b0000;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_s;
         ptr_r     <= ptr_s;
         sel       <= sel_s;
         out_valid <= out_valid_s;
         out_data  <= out_data_s;
         ack       <= ack_s;
         busy      <= busy_s;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a per-cycle vector table plus hand-written corner
// sequences, with accepted words checked against a queue of expected grants.
module tb_mux_rr_arbiter;

   localparam int W = 8;

   logic           clk;
   logic           rst;
   logic [3:0]     req;
   logic [4*W-1:0] in_data;
   logic [3:0]     ack;
   logic [1:0]     sel;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic           busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic        rdy;
      logic        push;
      logic [1:0]  psel;
      logic [7:0]  pdata;
      logic        e_valid;
      logic [1:0]  e_sel;
      logic [7:0]  e_data;
      logic        e_busy;
      logic [3:0]  e_ack;
   } vec_t;

   typedef struct {
      logic [1:0] sel;
      logic [7:0] data;
   } sb_t;

   vec_t vecs [11];
   sb_t  sb_q [$];
   sb_t  sb_e;

   mux_rr_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in_data   (in_data),
      .ack       (ack),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic ev, input logic [1:0] es,
                          input logic [7:0] ed, input logic eb, input logic [3:0] ea);
      chk({name, "_valid"}, 32'(out_valid), 32'(ev));
      chk({name, "_sel"},   32'(sel),       32'(es));
      chk({name, "_data"},  32'(out_data),  32'(ed));
      chk({name, "_busy"},  32'(busy),      32'(eb));
      chk({name, "_ack"},   32'(ack),       32'(ea));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] s, input logic [7:0] d);
      sb_t e;
      e.sel  = s;
      e.data = d;
      sb_q.push_back(e);
   endtask

   // Scoreboard: a word accepted on the coming edge must match the oldest expected grant.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: accepted sel %0d data %0h with nothing expected", sel, out_data);
         end else begin
            sb_e = sb_q.pop_front();
            chk("sb_sel",  32'(sel),      32'(sb_e.sel));
            chk("sb_data", 32'(out_data), 32'(sb_e.data));
         end
      end
   end

   initial begin
      // Vector table: inputs for one edge, expected outputs just after it. Starts with ptr = 0.
      vecs[0]  = '{4'b0100, 32'h00A50000, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b1, 2'd2, 8'hA5, 1'b1, 4'b0000};
      vecs[1]  = '{4'b0100, 32'h00A50000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 8'hA5, 1'b0, 4'b0100};
      vecs[2]  = '{4'b0000, 32'h00A50000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 8'hA5, 1'b0, 4'b0000};
      vecs[3]  = '{4'b0001, 32'h0000003C, 1'b0, 1'b1, 2'd0, 8'h3C, 1'b1, 2'd0, 8'h3C, 1'b1, 4'b0000};
      for (int i = 4; i <= 8; i++) begin
         vecs[i] = '{4'b0001, 32'h0000003C, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h3C, 1'b1, 4'b0000};
      end
      vecs[9]  = '{4'b0001, 32'h0000003C, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h3C, 1'b0, 4'b0001};
      vecs[10] = '{4'b0000, 32'h0000003C, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h3C, 1'b0, 4'b0000};

      // Reset with random inputs, then release with idle inputs.
      rst = 1'b1;
      req = 4'b0000;
      in_data = 32'h0;
      out_ready = 1'b0;
      repeat (3) begin
         req       = 4'($urandom);
         in_data   = $urandom;
         out_ready = 1'($urandom);
         step();
         chk_out("rst_hold", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
      end
      rst = 1'b0;
      req = 4'b0000;
      in_data = 32'h0;
      out_ready = 1'b0;
      #1;
      chk_out("rst_rel", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);

      for (int i = 0; i < 11; i++) begin
         req       = vecs[i].req;
         in_data   = vecs[i].data;
         out_ready = vecs[i].rdy;
         if (vecs[i].push) push_exp(vecs[i].psel, vecs[i].pdata);
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sel, vecs[i].e_data,
                 vecs[i].e_busy, vecs[i].e_ack);
      end

      // Withdrawal: requester 1 drops req while granted; transfer still completes (ptr = 1 here).
      req = 4'b0010; in_data = 32'h00007700; out_ready = 1'b0;
      push_exp(2'd1, 8'h77);
      step();
      chk_out("wd_grant", 1'b1, 2'd1, 8'h77, 1'b1, 4'b0000);
      req = 4'b0000; in_data = 32'h0;
      step();
      chk_out("wd_hold", 1'b1, 2'd1, 8'h77, 1'b1, 4'b0000);
      out_ready = 1'b1;
      step();
      chk_out("wd_ack", 1'b0, 2'd1, 8'h77, 1'b0, 4'b0010);

      // Pointer wrap: serve 3, then 4'b1001 must go to 0, then 4'b1010 must go to 1.
      req = 4'b1000; in_data = 32'hC300B15A;
      push_exp(2'd3, 8'hC3);
      step();
      chk_out("wrap_g3", 1'b1, 2'd3, 8'hC3, 1'b1, 4'b0000);
      step();
      chk_out("wrap_a3", 1'b0, 2'd3, 8'hC3, 1'b0, 4'b1000);
      req = 4'b1001;
      push_exp(2'd0, 8'h5A);
      step();
      chk_out("wrap_g0", 1'b1, 2'd0, 8'h5A, 1'b1, 4'b0000);
      step();
      chk_out("wrap_a0", 1'b0, 2'd0, 8'h5A, 1'b0, 4'b0001);
      req = 4'b1010;
      push_exp(2'd1, 8'hB1);
      step();
      chk_out("wrap_g1", 1'b1, 2'd1, 8'hB1, 1'b1, 4'b0000);
      step();
      chk_out("wrap_a1", 1'b0, 2'd1, 8'hB1, 1'b0, 4'b0010);

      // Reset mid-GRANT: ptr = 2 grants 2; after reset ptr = 0 so 4'b0110 grants 1 first.
      req = 4'b0110; in_data = 32'h00D2E100; out_ready = 1'b0;
      step();
      chk_out("rmg_grant", 1'b1, 2'd2, 8'hD2, 1'b1, 4'b0000);
      rst = 1'b1;
      #1;
      chk_out("rmg_async", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
      #1;
      rst = 1'b0;
      push_exp(2'd1, 8'hE1);
      step();
      chk_out("rmg_regrant", 1'b1, 2'd1, 8'hE1, 1'b1, 4'b0000);
      out_ready = 1'b1;
      step();
      chk_out("rmg_ack1", 1'b0, 2'd1, 8'hE1, 1'b0, 4'b0010);
      req = 4'b0100;
      push_exp(2'd2, 8'hD2);
      step();
      chk_out("rmg_g2", 1'b1, 2'd2, 8'hD2, 1'b1, 4'b0000);
      step();
      chk_out("rmg_ack2", 1'b0, 2'd2, 8'hD2, 1'b0, 4'b0100);

      // Full contention from a fresh pointer: rotating grants, one transfer every 2 cycles.
      req = 4'b0000; out_ready = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      req = 4'b1111; in_data = 32'h44332211; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [1:0] e;
         logic [7:0] d;
         e = 2'(i % 4);
         d = 8'h11 * (8'(e) + 8'd1);
         push_exp(e, d);
         step();
         chk_out($sformatf("rr%0d_grant", i), 1'b1, e, d, 1'b1, 4'b0000);
         req = 4'b1111;
         step();
         chk_out($sformatf("rr%0d_ack", i), 1'b0, e, d, 1'b0, 4'b0001 << e);
         req[e] = 1'b0;
      end

      req = 4'b0000; out_ready = 1'b0;
      step();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
